// File: rtl/ahb_slv_pkg.sv
// Shared types and helpers for the AHB-Lite slave responder.
// - htrans_e / hsize_e : bus encodings
// - HRESP_OKAY / HRESP_ERROR : response encodings
// - slv_state_e : responder FSM states
// - byte_lane_mask() : little-endian byte enables for a (size, lane offset) pair
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    Size8    = 3'd0,
    Size16   = 3'd1,
    Size32   = 3'd2,
    Size64   = 3'd3,
    Size128  = 3'd4,
    Size256  = 3'd5,
    Size512  = 3'd6,
    Size1024 = 3'd7
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWait = 3'd1,
    StData = 3'd2,
    StErr1 = 3'd3,
    StErr2 = 3'd4
  } slv_state_e;

  // Byte enables for up to 8 lanes: 2**size ones shifted up to the lane offset.
  function automatic logic [7:0] byte_lane_mask(input logic [2:0] size, input logic [2:0] offset);
    logic [15:0] ones;
    ones = (16'd1 << (16'd1 << size)) - 16'd1;
    return 8'(ones << offset);
  endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// Word-organised byte-enable memory used as the responder's storage.
// Contents are not reset.
// Ports:
//   clk   - write clock
//   we    - write enable (committed on the rising edge)
//   be    - per-byte write enables
//   idx   - word index, shared by read and write
//   wdata - write data
//   rdata - asynchronous read data of word idx
module ahb_slv_mem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH),
  localparam int unsigned STRB_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [STRB_W-1:0] be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (be[b]) begin
          mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_lite_slv_responder.sv
// AHB-Lite slave with a word-addressed memory, optional wait states and a two-cycle ERROR response.
// Optional feature: define AHB_SLV_WAIT_STATE_EN to add the cfg_wait port (wait states per OKAY
// transfer, sampled at address accept). Without it every OKAY transfer is zero-wait.
// Ports:
//   hclk, hreset          - clock, asynchronous active-high reset
//   Hsel, Haddr, Htrans   - address phase select, byte address, transfer type
//   Hwrite, Hsize         - direction, transfer size (2**Hsize bytes)
//   Hburst, Hprot         - accepted, no effect on the response
//   Hwdata                - write data (data phase)
//   Hready_in             - bus HREADY
//   cfg_wait              - wait states per OKAY transfer (AHB_SLV_WAIT_STATE_EN only)
//   Hrdata, Hready_out, Hresp - read data, slave ready, response
module ahb_lite_slv_responder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
`ifdef AHB_SLV_WAIT_STATE_EN
  ,
  parameter int unsigned       WAIT_W    = 4
`endif
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              Hsel,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [1:0]        Htrans,
  input  logic              Hwrite,
  input  logic [2:0]        Hsize,
  input  logic [2:0]        Hburst,
  input  logic [3:0]        Hprot,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic              Hready_in,
`ifdef AHB_SLV_WAIT_STATE_EN
  input  logic [WAIT_W-1:0] cfg_wait,
`endif
  output logic [DATA_W-1:0] Hrdata,
  output logic              Hready_out,
  output logic              Hresp
);
  import ahb_slv_pkg::*;

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
`ifdef AHB_SLV_WAIT_STATE_EN
  localparam int unsigned CNT_W    = WAIT_W;
`else
  localparam int unsigned CNT_W    = 1;
`endif

  slv_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  wait_load;
  logic [IDX_W-1:0]  idx_q;
  logic [2:0]        byte_off_q;
  logic [2:0]        size_q;
  logic              write_q;

  htrans_e           trans;
  logic              can_accept;
  logic              accept;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        align_mask;
  logic              below_base;
  logic              above_top;
  logic              size_err;
  logic              misalign;
  logic              err_in;

  logic              mem_we;
  logic [STRB_W-1:0] mem_be;
  logic [DATA_W-1:0] mem_rdata;

  // Burst and protection attributes do not influence this responder.
  logic unused_attr;
  assign unused_attr = ^{Hburst, Hprot};

`ifdef AHB_SLV_WAIT_STATE_EN
  assign wait_load = cfg_wait;
`else
  assign wait_load = '0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Address phase decode
  // ---------------------------------------------------------------------------------------------
  assign trans = htrans_e'(Htrans);

  // A new address phase can only be taken while this slave is driving HREADY high.
  assign can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept     = can_accept && Hsel && Hready_in &&
                      ((trans == TransNonseq) || (trans == TransSeq));

  assign offset     = Haddr - BASE_ADDR;
  assign word_idx   = offset >> ADDR_LSB;
  assign below_base = Haddr < BASE_ADDR;
  assign above_top  = word_idx >= ADDR_W'(MEM_DEPTH);
  assign size_err   = Hsize > 3'(ADDR_LSB);
  assign align_mask = (8'd1 << Hsize) - 8'd1;
  assign misalign   = |(Haddr[7:0] & align_mask);
  assign err_in     = below_base | above_top | size_err | misalign;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      idx_q      <= '0;
      byte_off_q <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
    end else if (accept) begin
      idx_q      <= IDX_W'(word_idx);
      byte_off_q <= 3'(Haddr & ADDR_W'(STRB_W - 1));
      size_q     <= Hsize;
      write_q    <= Hwrite;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Response FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StWait: begin
        // The counter holds the wait cycles still owed including this one.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      default: begin
        // Idle, Data and Err2 all complete with HREADY high, so a pipelined address
        // phase arriving here is handled identically.
        state_d = StIdle;
        if (accept) begin
          if (err_in) begin
            state_d = StErr1;
          end else if (wait_load != '0) begin
            state_d = StWait;
            cnt_d   = wait_load;
          end else begin
            state_d = StData;
          end
        end
      end
    endcase
  end

  assign Hready_out = !((state_q == StWait) || (state_q == StErr1));
  assign Hresp      = ((state_q == StErr1) || (state_q == StErr2)) ? HRESP_ERROR : HRESP_OKAY;
  assign Hrdata     = ((state_q == StData) && !write_q) ? mem_rdata : '0;

  // ---------------------------------------------------------------------------------------------
  // Storage: write commits on the edge that ends the data cycle; errored transfers never
  // reach StData so they cannot write.
  // ---------------------------------------------------------------------------------------------
  assign mem_we = (state_q == StData) && write_q;
  assign mem_be = STRB_W'(byte_lane_mask(size_q, byte_off_q));

  ahb_slv_mem #(
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk  (hclk),
    .we   (mem_we),
    .be   (mem_be),
    .idx  (idx_q),
    .wdata(Hwdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_ahb_lite_slv_responder.sv
// Self-checking bench for ahb_lite_slv_responder (32-bit data, 1024 words, base 0).
// Directed cases plus randomized transfers checked against a word-array reference model.
module tb_ahb_lite_slv_responder;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready_in;
  logic [31:0] hrdata;
  logic        hready_out;
  logic        hresp;
`ifdef AHB_SLV_WAIT_STATE_EN
  logic [3:0]  cfg_wait;
`endif

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cur_wait = 0;
  logic [31:0] mdl [64];

  // Single slave on the bus: bus HREADY is this slave's HREADY.
  assign hready_in = hready_out;

  always #5 hclk = ~hclk;

  ahb_lite_slv_responder #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MEM_DEPTH(1024),
    .BASE_ADDR(32'h0)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .Hsel      (hsel),
    .Haddr     (haddr),
    .Htrans    (htrans),
    .Hwrite    (hwrite),
    .Hsize     (hsize),
    .Hburst    (hburst),
    .Hprot     (hprot),
    .Hwdata    (hwdata),
    .Hready_in (hready_in),
`ifdef AHB_SLV_WAIT_STATE_EN
    .cfg_wait  (cfg_wait),
`endif
    .Hrdata    (hrdata),
    .Hready_out(hready_out),
    .Hresp     (hresp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_wait(input int w);
`ifdef AHB_SLV_WAIT_STATE_EN
    cfg_wait = 4'(w);
    cur_wait = w;
`else
    cur_wait = 0;
`endif
  endtask

  // One non-pipelined transfer. Called and returns #1 after a rising edge with the slave ready.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output int lo_cycles, output logic lo_resp, output logic fin_resp);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    hburst = 3'($urandom_range(0, 7));
    hprot  = 4'($urandom_range(0, 15));
    @(posedge hclk); #1;
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = wdata;
    lo_cycles = 0;
    lo_resp   = 1'b0;
    while (!hready_out && lo_cycles < 40) begin
      lo_resp = lo_resp | hresp;
      lo_cycles++;
      @(posedge hclk); #1;
    end
    if (!hready_out) check_eq("timeout_hready", 32'(hready_out), 32'd1);
    rdata    = hrdata;
    fin_resp = hresp;
    @(posedge hclk); #1;
  endtask

  // Runs a transfer and checks it against the reference model.
  task automatic xfer_chk(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata);
    logic [31:0] rd;
    int          lo;
    logic        lor;
    logic        fr;
    logic        err;
    int          w;
    err = (addr >= 32'h1000) || (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
    do_xfer(wr, addr, size, wdata, rd, lo, lor, fr);
    w = int'(addr >> 2);
    if (err) begin
      check_eq({tag, ".err_lo_cycles"}, lo, 1);
      check_eq({tag, ".err_lo_resp"}, 32'(lor), 32'd1);
      check_eq({tag, ".err_resp"}, 32'(fr), 32'd1);
    end else begin
      check_eq({tag, ".wait_cycles"}, lo, cur_wait);
      check_eq({tag, ".wait_resp"}, 32'(lor), 32'd0);
      check_eq({tag, ".resp"}, 32'(fr), 32'd0);
      if (wr) begin
        for (int b = 0; b < (1 << size); b++) begin
          int lane;
          lane = int'(addr % 4) + b;
          mdl[w][lane*8 +: 8] = wdata[lane*8 +: 8];
        end
      end else begin
        check_eq({tag, ".rdata"}, rd, mdl[w]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lo;
    logic        lor;
    logic        fr;

    hreset = 1'b1;
    hsel   = 1'b0;
    haddr  = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hburst = '0;
    hprot  = '0;
    hwdata = '0;
    set_wait(0);
    repeat (2) @(posedge hclk);
    #1;
    check_eq("reset.hready", 32'(hready_out), 32'd1);
    check_eq("reset.hresp", 32'(hresp), 32'd0);
    check_eq("reset.hrdata", hrdata, 32'd0);
    hreset = 1'b0;
    @(posedge hclk); #1;

    // Give the modelled region known contents.
    for (int i = 0; i < 64; i++) xfer_chk("init", 1'b1, 32'(i * 4), 3'd2, $urandom);

    // Word write then read.
    xfer_chk("wr10", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    do_xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lo, lor, fr);
    check_eq("rd10.rdata", rd, 32'hDEADBEEF);
    check_eq("rd10.cycles", lo, 0);
    check_eq("rd10.resp", 32'(fr), 32'd0);

    // Byte write into lane 3.
    xfer_chk("wr10b", 1'b1, 32'h10, 3'd2, 32'h11223344);
    xfer_chk("wr13", 1'b1, 32'h13, 3'd0, 32'hAA00_0000);
    do_xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lo, lor, fr);
    check_eq("rd10_byte.rdata", rd, 32'hAA223344);

    // Back-to-back write then read of the same word, no idle cycle.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hwdata = 32'h5;
    hwrite = 1'b0;
    check_eq("b2b.wr_ready", 32'(hready_out), 32'd1);
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    lo = 0;
    while (!hready_out && lo < 40) begin
      lo++;
      @(posedge hclk); #1;
    end
    check_eq("b2b.rd_resp", 32'(hresp), 32'd0);
    check_eq("b2b.rdata", hrdata, 32'h5);
    mdl[8] = 32'h5;
    @(posedge hclk); #1;

    // Out-of-range read and misaligned write: two-cycle ERROR, memory untouched.
    xfer_chk("oor1000", 1'b0, 32'h1000, 3'd2, 32'h0);
    xfer_chk("after_oor", 1'b0, 32'h10, 3'd2, 32'h0);
    xfer_chk("misal2", 1'b1, 32'h2, 3'd2, 32'hFFFF_FFFF);
    xfer_chk("after_misal", 1'b0, 32'h0, 3'd2, 32'h0);
    xfer_chk("size3", 1'b0, 32'h8, 3'd3, 32'h0);

`ifdef AHB_SLV_WAIT_STATE_EN
    set_wait(3);
    xfer_chk("wait3_wr", 1'b1, 32'h30, 3'd2, 32'h0BAD_CAFE);
    xfer_chk("wait3_rd", 1'b0, 32'h30, 3'd2, 32'h0);
    set_wait(0);
    xfer_chk("wait0_wr", 1'b1, 32'h34, 3'd2, 32'h1357_9BDF);
    xfer_chk("wait0_rd", 1'b0, 32'h34, 3'd2, 32'h0);
    set_wait(3);
`endif

    // Reset during the data/wait phase of a write to 0x40 discards it.
    xfer_chk("pre_rst_wr", 1'b1, 32'h40, 3'd2, 32'h1234_5678);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
    hreset = 1'b1;
    #1;
    check_eq("rst_mid.hready", 32'(hready_out), 32'd1);
    check_eq("rst_mid.hresp", 32'(hresp), 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;
    xfer_chk("post_rst_rd", 1'b0, 32'h40, 3'd2, 32'h0);

    // Randomized transfers.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [2:0]  s;
      logic        wr;
      s  = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 63) * 4);
      else a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
      wr = 1'($urandom_range(0, 1));
      set_wait($urandom_range(0, 3));
      xfer_chk($sformatf("rnd%0d", n), wr, a, s, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
